// File: rtl/sha_multi_add_pipe.sv
// Two-stage pipelined multi-operand modular adder: a carry-save tree compresses all
// operands plus carry-in to two vectors, then a segmented carry-lookahead adder finishes.
module sha_multi_add_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 5,
  parameter int SEG     = 8,
  localparam int CW     = ($clog2(NUM_OPS) > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_OPS*WIDTH-1:0] i_ops,
  input  logic                     i_carry,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_summ,
  output logic [CW-1:0]            o_carry
);

  localparam int XW    = WIDTH + CW;
  localparam int NSEG  = (XW + SEG - 1) / SEG;
  localparam int LASTW = XW - (NSEG - 1) * SEG;
  localparam int NIN   = NUM_OPS + 1;

  // Vectors remaining after lvl rounds of 3:2 compression, starting from n.
  function automatic int treeCount(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) begin
      if (c > 2) c = 2 * (c / 3) + c % 3;
    end
    return c;
  endfunction

  function automatic int treeLevels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + c % 3;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = treeLevels(NIN);

  logic          r_v1;
  logic          r_v2;
  logic [XW-1:0] r_vecA;
  logic [XW-1:0] r_vecB;
  logic [WIDTH-1:0] r_summ;
  logic [CW-1:0] r_carry;

  logic          w_en1;
  logic          w_en2;
  logic [XW-1:0] w_tree [0:LEVELS][0:NUM_OPS];
  logic [XW-1:0] w_sum;
  logic [NSEG-2:0] w_segG;
  logic [NSEG-2:0] w_segP;
  logic [NSEG-1:0] w_segC;

  assign w_en2   = ~r_v2 | i_ready;
  assign w_en1   = ~r_v1 | w_en2;
  assign o_ready = w_en1;
  assign o_valid = r_v2;
  assign o_summ  = r_summ;
  assign o_carry = r_carry;

  genvar gk, gl, gi, gs;

  for (gk = 0; gk < NUM_OPS; gk++) begin : g_load
    assign w_tree[0][gk] = {{CW{1'b0}}, i_ops[gk*WIDTH +: WIDTH]};
  end
  assign w_tree[0][NUM_OPS] = XW'(i_carry);

  // Each level compresses every full group of three into sum and shifted majority;
  // leftover vectors pass straight through, unused slots are tied to zero.
  for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
    localparam int N  = treeCount(NIN, gl);
    localparam int G  = N / 3;
    localparam int NN = 2 * G + N % 3;
    for (gi = 0; gi < NIN; gi++) begin : g_slot
      if (gi < 2 * G && gi % 2 == 0) begin : g_sum
        assign w_tree[gl+1][gi] = w_tree[gl][3*(gi/2)] ^ w_tree[gl][3*(gi/2)+1]
                                ^ w_tree[gl][3*(gi/2)+2];
      end else if (gi < 2 * G) begin : g_maj
        assign w_tree[gl+1][gi] = ((w_tree[gl][3*(gi/2)]   & w_tree[gl][3*(gi/2)+1])
                                 | (w_tree[gl][3*(gi/2)]   & w_tree[gl][3*(gi/2)+2])
                                 | (w_tree[gl][3*(gi/2)+1] & w_tree[gl][3*(gi/2)+2])) << 1;
      end else if (gi < NN) begin : g_pass
        assign w_tree[gl+1][gi] = w_tree[gl][G+gi];
      end else begin : g_zero
        assign w_tree[gl+1][gi] = '0;
      end
    end
  end

  for (gs = 0; gs < NSEG; gs++) begin : g_seg
    if (gs < NSEG - 1) begin : g_full
      logic [SEG:0] w_raw;
      assign w_raw = {1'b0, r_vecA[gs*SEG +: SEG]} + {1'b0, r_vecB[gs*SEG +: SEG]};
      assign w_segG[gs] = w_raw[SEG];
      assign w_segP[gs] = &(r_vecA[gs*SEG +: SEG] ^ r_vecB[gs*SEG +: SEG]);
      assign w_sum[gs*SEG +: SEG] = w_raw[SEG-1:0] + SEG'(w_segC[gs]);
    end else begin : g_last
      assign w_sum[XW-1 -: LASTW] = r_vecA[XW-1 -: LASTW] + r_vecB[XW-1 -: LASTW]
                                  + LASTW'(w_segC[gs]);
    end
  end

  // Segment carry-in s is any lower generate whose carry propagates through every segment between.
  always_comb begin : g_lookahead
    logic w_term;
    w_term = 1'b0;
    w_segC = '0;
    for (int s = 1; s < NSEG; s++) begin
      for (int j = 0; j < s; j++) begin
        w_term = w_segG[j];
        for (int m = j + 1; m < s; m++) w_term = w_term & w_segP[m];
        w_segC[s] = w_segC[s] | w_term;
      end
    end
  end

  // Data registers load only on a valid advance so idle-cycle input garbage never reaches the outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_vecA  <= '0;
      r_vecB  <= '0;
      r_summ  <= '0;
      r_carry <= '0;
    end else begin
      if (w_en1) begin
        r_v1 <= i_valid;
        if (i_valid) begin
          r_vecA <= w_tree[LEVELS][0];
          r_vecB <= w_tree[LEVELS][1];
        end
      end
      if (w_en2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_summ  <= w_sum[WIDTH-1:0];
          r_carry <= w_sum[XW-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_multi_add_pipe.sv
// Bench for sha_multi_add_pipe: arithmetic reference model plus scoreboard on the default
// configuration, and directed/random checks on a 16-bit two-operand instance.
module tb_sha_multi_add_pipe;

  localparam int W = 32;
  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstN;
  logic           inValid;
  logic           dutReady;
  logic [N*W-1:0] ops;
  logic           carryIn;
  logic           dutValid;
  logic           sinkReady;
  logic [W-1:0]   summ;
  logic [2:0]     carryOut;

  logic        bInValid;
  logic        bReady;
  logic [31:0] bOps;
  logic        bCarryIn;
  logic        bValid;
  logic        bSinkReady;
  logic [15:0] bSumm;
  logic        bCarryOut;

  sha_multi_add_pipe dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(inValid), .o_ready(dutReady),
    .i_ops(ops), .i_carry(carryIn), .o_valid(dutValid), .i_ready(sinkReady),
    .o_summ(summ), .o_carry(carryOut)
  );

  sha_multi_add_pipe #(.WIDTH(16), .NUM_OPS(2), .SEG(4)) dutSmall (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(bInValid), .o_ready(bReady),
    .i_ops(bOps), .i_carry(bCarryIn), .o_valid(bValid), .i_ready(bSinkReady),
    .o_summ(bSumm), .o_carry(bCarryOut)
  );

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  logic [34:0] expQ[$];
  logic lastInXfer = 1'b0;
  logic holdValid = 1'b0;
  logic [W-1:0] holdSumm = '0;
  logic [2:0] holdCarry = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Full-precision total; bits [31:0] are the sum, [34:32] the overflow count.
  function automatic logic [34:0] modelSum(input logic [N*W-1:0] o, input logic c);
    longint unsigned t;
    t = longint'(c);
    for (int k = 0; k < N; k++) t += longint'(o[k*W +: W]);
    return t[34:0];
  endfunction

  function automatic logic [N*W-1:0] randOps();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] o, input logic c);
    inValid = 1'b1;
    ops     = o;
    carryIn = c;
  endtask

  task automatic idle();
    inValid = 1'b0;
    ops     = randOps();
    carryIn = 1'(($urandom() & 32'h1));
  endtask

  // Scoreboard: inputs are stable between posedge+1 and the next posedge, so the negedge
  // sees exactly the handshakes that the coming edge will perform.
  always @(negedge clk) begin
    if (rstN !== 1'b1) begin
      expQ.delete();
      holdValid  = 1'b0;
      lastInXfer = 1'b0;
    end else begin
      checkOutput("o_ready", {63'd0, dutReady}, {63'd0, !(expQ.size() == 2 && !sinkReady)});
      if (holdValid) begin
        checkOutput("hold_valid", {63'd0, dutValid}, 64'd1);
        checkOutput("hold_summ", 64'(summ), 64'(holdSumm));
        checkOutput("hold_carry", 64'(carryOut), 64'(holdCarry));
      end
      if (dutValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", {63'd0, dutValid}, 64'd0);
        end else begin
          checkOutput("summ", 64'(summ), 64'(expQ[0][31:0]));
          checkOutput("carry", 64'(carryOut), 64'(expQ[0][34:32]));
          if (sinkReady) begin
            void'(expQ.pop_front());
            outCount++;
          end
        end
      end
      holdValid  = dutValid && !sinkReady;
      holdSumm   = summ;
      holdCarry  = carryOut;
      lastInXfer = inValid && dutReady;
      if (lastInXfer) expQ.push_back(modelSum(ops, carryIn));
    end
  end

  task automatic directedCheck(input string name, input logic [N*W-1:0] o, input logic c,
                               input logic [31:0] expS, input logic [2:0] expC);
    sinkReady = 1'b1;
    applyStimulus(o, c);
    checkOutput({name, "_ready"}, {63'd0, dutReady}, 64'd1);
    step();
    idle();
    checkOutput({name, "_lat1"}, {63'd0, dutValid}, 64'd0);
    step();
    checkOutput({name, "_valid"}, {63'd0, dutValid}, 64'd1);
    checkOutput({name, "_summ"}, 64'(summ), 64'(expS));
    checkOutput({name, "_carry"}, 64'(carryOut), 64'(expC));
    step();
    step();
  endtask

  task automatic smallCheck(input string name, input logic [15:0] op1, input logic [15:0] op0,
                            input logic c, input logic [15:0] expS, input logic expC);
    bInValid = 1'b1;
    bOps     = {op1, op0};
    bCarryIn = c;
    checkOutput({name, "_ready"}, {63'd0, bReady}, 64'd1);
    step();
    bInValid = 1'b0;
    bOps     = $urandom();
    checkOutput({name, "_lat1"}, {63'd0, bValid}, 64'd0);
    step();
    checkOutput({name, "_valid"}, {63'd0, bValid}, 64'd1);
    checkOutput({name, "_summ"}, 64'(bSumm), 64'(expS));
    checkOutput({name, "_carry"}, {63'd0, bCarryOut}, {63'd0, expC});
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, elapsed %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [N*W-1:0] opsA, opsB, opsC;
    logic [15:0] x0, x1;
    logic xc;
    logic [16:0] xt;

    rstN       = 1'b0;
    sinkReady  = 1'b1;
    bSinkReady = 1'b1;
    bInValid   = 1'b0;
    bOps       = '0;
    bCarryIn   = 1'b0;
    idle();
    step();
    step();
    checkOutput("rst_valid", {63'd0, dutValid}, 64'd0);
    checkOutput("rst_summ", 64'(summ), 64'd0);
    checkOutput("rst_carry", 64'(carryOut), 64'd0);
    checkOutput("rst_ready", {63'd0, dutReady}, 64'd1);
    checkOutput("rst_small_valid", {63'd0, bValid}, 64'd0);
    checkOutput("rst_small_summ", 64'(bSumm), 64'd0);
    rstN = 1'b1;
    step();

    directedCheck("ops54321", {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 32'h0000_000F, 3'd0);
    directedCheck("all_ones", {5{32'hFFFF_FFFF}}, 1'b1, 32'hFFFF_FFFC, 3'd4);
    directedCheck("two_msb", {32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, 1'b0, 32'h0, 3'd1);

    $display("[TB] streaming 100 back-to-back transactions");
    base = outCount;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(randOps(), 1'(($urandom() & 32'h1)));
      step();
    end
    idle();
    repeat (3) step();
    checkOutput("stream_count", 64'(outCount - base), 64'd100);

    $display("[TB] backpressure with three offered transactions");
    opsA = {5{32'd1}};
    opsB = {5{32'd2}};
    opsC = {5{32'd3}};
    sinkReady = 1'b0;
    applyStimulus(opsA, 1'b0);
    checkOutput("bp_ready_a", {63'd0, dutReady}, 64'd1);
    step();
    applyStimulus(opsB, 1'b0);
    checkOutput("bp_ready_b", {63'd0, dutReady}, 64'd1);
    step();
    applyStimulus(opsC, 1'b0);
    checkOutput("bp_ready_low", {63'd0, dutReady}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp_stall_ready", {63'd0, dutReady}, 64'd0);
      checkOutput("bp_stall_valid", {63'd0, dutValid}, 64'd1);
      checkOutput("bp_stall_summ", 64'(summ), 64'd5);
    end
    sinkReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", {63'd0, dutReady}, 64'd1);
    step();
    idle();
    checkOutput("bp_second_summ", 64'(summ), 64'd10);
    step();
    checkOutput("bp_third_summ", 64'(summ), 64'd15);
    checkOutput("bp_third_valid", {63'd0, dutValid}, 64'd1);
    step();
    checkOutput("bp_drained", {63'd0, dutValid}, 64'd0);

    $display("[TB] random valid/ready toggling for 1000 cycles");
    for (int i = 0; i < 1000; i++) begin
      sinkReady = 1'(($urandom() & 32'h1));
      if (!(inValid && !lastInXfer)) begin
        if (($urandom() & 32'h1) != 0) applyStimulus(randOps(), 1'(($urandom() & 32'h1)));
        else idle();
      end
      step();
    end
    idle();
    sinkReady = 1'b1;
    repeat (4) step();
    checkOutput("random_drain_queue", 64'(expQ.size()), 64'd0);
    checkOutput("random_drain_valid", {63'd0, dutValid}, 64'd0);

    $display("[TB] reset with both stages full");
    sinkReady = 1'b0;
    applyStimulus(randOps(), 1'b1);
    step();
    applyStimulus(randOps(), 1'b0);
    step();
    idle();
    checkOutput("full_valid", {63'd0, dutValid}, 64'd1);
    checkOutput("full_ready", {63'd0, dutReady}, 64'd0);
    rstN = 1'b0;
    step();
    checkOutput("midrst_valid", {63'd0, dutValid}, 64'd0);
    checkOutput("midrst_summ", 64'(summ), 64'd0);
    checkOutput("midrst_carry", 64'(carryOut), 64'd0);
    checkOutput("midrst_ready", {63'd0, dutReady}, 64'd1);
    rstN = 1'b1;
    sinkReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("post_rst_no_stale", {63'd0, dutValid}, 64'd0);
    end

    $display("[TB] 16-bit two-operand instance");
    smallCheck("s_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    smallCheck("s_2p1", 16'h0002, 16'h0001, 1'b0, 16'h0003, 1'b0);
    smallCheck("s_msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      x0 = 16'($urandom());
      x1 = 16'($urandom());
      xc = 1'(($urandom() & 32'h1));
      xt = 17'(x0) + 17'(x1) + 17'(xc);
      smallCheck("s_rand", x1, x0, xc, xt[15:0], xt[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_multi_add_pipe.md
Name: sha_multi_add_pipe

Overview:
- Parametrised, pipelined multi-operand modular adder for the SHA-256 datapath.
- Reduces NUM_OPS operands plus a carry-in to one WIDTH-bit sum, for example T1 = h + Sigma1 + Ch + K + W.
- Also reports the full-precision overflow count.
- Two registered stages with valid/ready handshakes on both sides: carry-save reduction, then a segmented carry-lookahead final add. Sustains one result per cycle.

Parameters:
- WIDTH, 32, operand and sum width in bits (8..64).
- NUM_OPS, 5, number of operands summed (2..16).
- SEG, 8, carry-lookahead segment width for the final adder. WIDTH must be a multiple of SEG.
- CW, derived: max(1, $clog2(NUM_OPS)). Width of the overflow count. Not user-overridable.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  upstream presents a transaction.
- o_ready  out  1  block accepts a transaction this cycle.
- i_ops  in  NUM_OPS*WIDTH  packed operands; operand k at [k*WIDTH +: WIDTH].
- i_carry  in  1  carry-in added to the total.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts the result.
- o_summ  out  WIDTH  (sum of operands + i_carry) mod 2^WIDTH.
- o_carry  out  CW  floor((sum of operands + i_carry) / 2^WIDTH).

Behaviour:
- Reset:
  - When i_rst_n=0 at a rising edge: stage valids v1, v2 clear to 0, and all data registers clear to 0.
  - After that edge: o_valid=0, o_summ=0, o_carry=0, o_ready=1.
  - Reset mid-operation discards all in-flight transactions; nothing is replayed.
- Handshake:
  - Transfer in occurs when i_valid & o_ready.
  - Transfer out occurs when o_valid & i_ready.
  - i_ops and i_carry are sampled only on an input transfer.
  - Once o_valid=1, o_summ and o_carry hold stable until the output transfer.
- Pipeline enables:
  - en2 = ~v2 | i_ready.
  - en1 = ~v1 | en2.
  - o_ready = en1, which is combinational from i_ready. No other combinational input-to-output path.
- Stage 1, on en1:
  - v1 <= i_valid.
  - Operands and i_carry are reduced by a 3:2 carry-save tree to two vectors, each WIDTH+CW bits wide.
  - i_carry enters as bit 0 of a tree vector.
  - Tree depth is about log1.5(NUM_OPS), all combinational within the stage.
- Stage 2, on en2:
  - v2 <= v1.
  - Registers the (WIDTH+CW)-bit final add of the two vectors, computed with per-SEG generate/propagate and a lookahead over segment carries.
  - Lower WIDTH bits go to o_summ; the upper CW bits go to o_carry.
  - o_valid = v2.
- Latency: exactly 2 cycles from input transfer to o_valid when i_ready=1. Throughput 1 transaction per cycle.
- Backpressure:
  - With i_ready=0, at most 2 transactions are held (v1, v2).
  - o_ready drops to 0 only when both are valid.
  - Order is strictly preserved; no drops or duplicates.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with both stages full is legal; the pipeline shifts and stays full.
  - i_valid=0 while en1=1 clears v1 (bubble).
- Arithmetic:
  - Unsigned. Maximum total is NUM_OPS*(2^WIDTH-1)+1.
  - The upper part is at most NUM_OPS-1, which always fits in CW bits, so o_carry never truncates.
- Stalls hold all registers; X on i_ops while i_valid=0 must not propagate to the outputs.

Test Plan:
- Default parameters; i_ops = {5,4,3,2,1}, i_carry=0, i_ready=1 -> 2 cycles later o_valid=1, o_summ=0x0000000F, o_carry=0.
- All five operands 0xFFFFFFFF, i_carry=1 -> o_summ=0xFFFFFFFC, o_carry=4. Then two operands 0x80000000, rest 0 -> o_summ=0, o_carry=1.
- Stream 100 random back-to-back transactions with i_ready=1 -> one result per cycle, each matching the reference model (sum mod 2^32, sum>>32), in order.
- Hold i_ready=0 and offer 3 transactions:
  - First two are accepted; o_ready=0 from the cycle after the 2nd transfer; the third is held with stable i_ops.
  - Raise i_ready -> results emerge in order, the third is accepted the same cycle, and o_summ holds stable while stalled.
- Random i_valid and i_ready toggling for 1000 cycles -> scoreboard shows no loss, duplication or reordering, and o_summ/o_carry are stable whenever o_valid & ~i_ready.
- Assert i_rst_n=0 for 1 cycle with both stages full -> next cycle o_valid=0, o_summ=0, o_carry=0, o_ready=1; no stale result ever appears.
- Repeat the directed tests with WIDTH=16, NUM_OPS=2, SEG=4: 0xFFFF+0xFFFF+1 -> o_summ=0xFFFF, o_carry=1.
